// File: rtl/led_axil_req_arbiter.sv
// Round-robin arbiter funnelling two register requesters into one AXI4-Lite master port.
// Latency: 4 cycles from accept to response at a zero-wait slave; one transaction outstanding.
module led_axil_req_arbiter #(
    parameter int          C_M_AXI_ADDR_WIDTH = 32,
    parameter int          C_M_AXI_DATA_WIDTH = 32,
    parameter logic [31:0] BASE_ADDR          = 32'h43C0_0000,
    parameter int          IDX_W              = 2
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic                            req0_valid,
    input  logic                            req0_we,
    input  logic [IDX_W-1:0]                req0_idx,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   req0_wdata,
    output logic                            req0_ready,
    input  logic                            req1_valid,
    input  logic                            req1_we,
    input  logic [IDX_W-1:0]                req1_idx,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   req1_wdata,
    output logic                            req1_ready,
    output logic                            resp0_valid,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   resp0_rdata,
    output logic [1:0]                      resp0_resp,
    output logic                            resp1_valid,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   resp1_rdata,
    output logic [1:0]                      resp1_resp,
    output logic                            busy,
    output logic [7:0]                      err_cnt,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int AW = C_M_AXI_ADDR_WIDTH;

    typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_DONE} state_t;

    state_t          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic            gnt_q, gnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            awvalid_q, awvalid_d;
    logic            wvalid_q, wvalid_d;
    logic            bready_q, bready_d;
    logic            arvalid_q, arvalid_d;
    logic            rready_q, rready_d;
    logic [1:0]      rcode_q, rcode_d;
    logic [DW-1:0]   rdata_cap_q, rdata_cap_d;
    logic            resp0_valid_q, resp0_valid_d;
    logic            resp1_valid_q, resp1_valid_d;
    logic [DW-1:0]   resp0_rdata_q, resp0_rdata_d;
    logic [DW-1:0]   resp1_rdata_q, resp1_rdata_d;
    logic [1:0]      resp0_resp_q, resp0_resp_d;
    logic [1:0]      resp1_resp_q, resp1_resp_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic            busy_q, busy_d;

    logic            grant1, req0_rdy, req1_rdy, sel_we;
    logic [IDX_W-1:0] sel_idx;
    logic [DW-1:0]   sel_wdata;
    logic [31:0]     addr_full;

    // req1 wins only when req0 is absent or req0 was served last
    assign grant1    = req1_valid && (!req0_valid || !last_grant_q);
    assign sel_we    = grant1 ? req1_we    : req0_we;
    assign sel_idx   = grant1 ? req1_idx   : req0_idx;
    assign sel_wdata = grant1 ? req1_wdata : req0_wdata;
    assign addr_full = BASE_ADDR + {{(32-IDX_W-2){1'b0}}, sel_idx, 2'b00};

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        gnt_d         = gnt_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        rcode_d       = rcode_q;
        rdata_cap_d   = rdata_cap_q;
        resp0_valid_d = 1'b0;
        resp1_valid_d = 1'b0;
        resp0_rdata_d = resp0_rdata_q;
        resp1_rdata_d = resp1_rdata_q;
        resp0_resp_d  = resp0_resp_q;
        resp1_resp_d  = resp1_resp_q;
        err_cnt_d     = err_cnt_q;
        req0_rdy      = 1'b0;
        req1_rdy      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req0_valid || req1_valid) begin
                    req0_rdy     = !grant1;
                    req1_rdy     = grant1;
                    gnt_d        = grant1;
                    last_grant_d = grant1;
                    addr_d       = addr_full[AW-1:0];
                    wdata_d      = sel_wdata;
                    if (sel_we) begin
                        state_d   = S_WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = S_RD_ADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            S_WR: begin
                // AW and W retire independently; B is only accepted once both are gone
                if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = S_WR_RESP;
                    bready_d = 1'b1;
                end
            end
            S_WR_RESP: begin
                if (bready_q && M_AXI_BVALID) begin
                    rcode_d     = M_AXI_BRESP;
                    rdata_cap_d = '0;
                    bready_d    = 1'b0;
                    state_d     = S_DONE;
                end
            end
            S_RD_ADDR: begin
                if (arvalid_q && M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (rready_q && M_AXI_RVALID) begin
                    rcode_d     = M_AXI_RRESP;
                    rdata_cap_d = M_AXI_RDATA;
                    rready_d    = 1'b0;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (gnt_q) begin
                    resp1_valid_d = 1'b1;
                    resp1_rdata_d = rdata_cap_q;
                    resp1_resp_d  = rcode_q;
                end else begin
                    resp0_valid_d = 1'b1;
                    resp0_rdata_d = rdata_cap_q;
                    resp0_resp_d  = rcode_q;
                end
                if (rcode_q != 2'b00 && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q       <= S_IDLE;
            last_grant_q  <= 1'b1;
            gnt_q         <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            rcode_q       <= 2'b00;
            rdata_cap_q   <= '0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            resp0_rdata_q <= '0;
            resp1_rdata_q <= '0;
            resp0_resp_q  <= 2'b00;
            resp1_resp_q  <= 2'b00;
            err_cnt_q     <= 8'h00;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            gnt_q         <= gnt_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            rcode_q       <= rcode_d;
            rdata_cap_q   <= rdata_cap_d;
            resp0_valid_q <= resp0_valid_d;
            resp1_valid_q <= resp1_valid_d;
            resp0_rdata_q <= resp0_rdata_d;
            resp1_rdata_q <= resp1_rdata_d;
            resp0_resp_q  <= resp0_resp_d;
            resp1_resp_q  <= resp1_resp_d;
            err_cnt_q     <= err_cnt_d;
            busy_q        <= busy_d;
        end
    end

    // accept pulses are combinational, so hold them off while reset is asserted
    assign req0_ready    = req0_rdy && ARESETN;
    assign req1_ready    = req1_rdy && ARESETN;
    assign resp0_valid   = resp0_valid_q;
    assign resp1_valid   = resp1_valid_q;
    assign resp0_rdata   = resp0_rdata_q;
    assign resp1_rdata   = resp1_rdata_q;
    assign resp0_resp    = resp0_resp_q;
    assign resp1_resp    = resp1_resp_q;
    assign busy          = busy_q;
    assign err_cnt       = err_cnt_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_led_axil_req_arbiter.sv
// Directed bench for led_axil_req_arbiter: behavioural AXI4-Lite slave plus per-requester
// response scoreboards filled at accept time and drained by a negedge monitor.
`timescale 1ns/1ps
module tb_led_axil_req_arbiter;
    localparam logic [31:0] BASE = 32'h43C0_0000;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          cyc;
    } exp_t;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0, req0_we = 1'b0, req1_we = 1'b0;
    logic [1:0]  req0_idx = '0, req1_idx = '0;
    logic [31:0] req0_wdata = '0, req1_wdata = '0;
    logic        req0_ready, req1_ready, resp0_valid, resp1_valid, busy;
    logic [31:0] resp0_rdata, resp1_rdata;
    logic [1:0]  resp0_resp, resp1_resp;
    logic [7:0]  err_cnt;
    logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR;
    logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
    logic        M_AXI_AWREADY = 1'b0, M_AXI_WREADY = 1'b0, M_AXI_ARREADY = 1'b0;
    logic        M_AXI_BVALID = 1'b0, M_AXI_RVALID = 1'b0;
    logic [1:0]  M_AXI_BRESP = 2'b00, M_AXI_RRESP = 2'b00;
    logic [31:0] M_AXI_RDATA = '0;

    int   n_total = 0;
    int   n_pass = 0;
    int   cyc = 0;
    exp_t q0[$];
    exp_t q1[$];

    // slave model state and knobs
    logic [31:0] smem [4];
    logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
    logic [3:0]  cap_wstrb = '0;
    logic [2:0]  cap_awprot = '1, cap_arprot = '1;
    bit          got_aw = 0, got_w = 0, rd_pend = 0, b_hs = 0, r_hs = 0;
    int          aw_wait = 0, aw_delay = 0;
    logic [1:0]  bresp_err = 2'b00;
    bit          r_withhold = 0;
    int          awv_cnt = 0, wv_cnt = 0, ovl_cnt = 0;

    led_axil_req_arbiter dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_idx(req0_idx), .req0_wdata(req0_wdata),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_idx(req1_idx), .req1_wdata(req1_wdata),
        .req1_ready(req1_ready),
        .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata), .resp0_resp(resp0_resp),
        .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata), .resp1_resp(resp1_resp),
        .busy(busy), .err_cnt(err_cnt),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWVALID(M_AXI_AWVALID),
        .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
        .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARVALID(M_AXI_ARVALID),
        .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
        .M_AXI_RREADY(M_AXI_RREADY)
    );

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Slave: decides READY/VALID at the negedge, handshakes complete at the following posedge.
    always @(negedge ACLK) begin
        if (!ARESETN) begin
            got_aw = 0; got_w = 0; rd_pend = 0; b_hs = 0; r_hs = 0; aw_wait = 0;
            M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
            M_AXI_BVALID = 0; M_AXI_RVALID = 0;
        end else begin
            if (b_hs) begin M_AXI_BVALID = 0; b_hs = 0; end
            if (r_hs) begin M_AXI_RVALID = 0; r_hs = 0; end
            if (got_aw && got_w && !M_AXI_BVALID) begin
                if (bresp_err == 2'b00) smem[cap_awaddr[3:2]] = cap_wdata;
                M_AXI_BRESP = bresp_err; M_AXI_BVALID = 1; got_aw = 0; got_w = 0;
            end
            if (rd_pend && !M_AXI_RVALID && !r_withhold) begin
                M_AXI_RDATA = smem[cap_araddr[3:2]]; M_AXI_RRESP = 2'b00; M_AXI_RVALID = 1; rd_pend = 0;
            end
            M_AXI_AWREADY = 0;
            if (M_AXI_AWVALID && !got_aw) begin
                if (aw_wait >= aw_delay) M_AXI_AWREADY = 1;
                else aw_wait++;
            end else aw_wait = 0;
            M_AXI_WREADY  = M_AXI_WVALID && !got_w;
            M_AXI_ARREADY = M_AXI_ARVALID && !rd_pend;
            if (M_AXI_AWVALID && M_AXI_AWREADY) begin got_aw = 1; cap_awaddr = M_AXI_AWADDR; cap_awprot = M_AXI_AWPROT; end
            if (M_AXI_WVALID && M_AXI_WREADY) begin got_w = 1; cap_wdata = M_AXI_WDATA; cap_wstrb = M_AXI_WSTRB; end
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin rd_pend = 1; cap_araddr = M_AXI_ARADDR; cap_arprot = M_AXI_ARPROT; end
            b_hs = M_AXI_BVALID && M_AXI_BREADY;
            r_hs = M_AXI_RVALID && M_AXI_RREADY;
            if (M_AXI_AWVALID) awv_cnt++;
            if (M_AXI_WVALID) wv_cnt++;
            if (M_AXI_BREADY && (M_AXI_AWVALID || M_AXI_WVALID)) ovl_cnt++;
        end
    end

    // Response monitor: every pulse must match the oldest expectation for that requester.
    always @(negedge ACLK) begin
        exp_t e;
        if (resp0_valid) begin
            check("resp0_expected", 32'(q0.size() != 0), 1);
            if (q0.size() != 0) begin
                e = q0.pop_front();
                check("resp0_rdata", resp0_rdata, e.rdata);
                check("resp0_resp", {30'b0, resp0_resp}, {30'b0, e.resp});
                if (e.cyc >= 0) check("resp0_latency", 32'(cyc), 32'(e.cyc));
            end
        end
        if (resp1_valid) begin
            check("resp1_expected", 32'(q1.size() != 0), 1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                check("resp1_rdata", resp1_rdata, e.rdata);
                check("resp1_resp", {30'b0, resp1_resp}, {30'b0, e.resp});
                if (e.cyc >= 0) check("resp1_latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic do_req(input int port, input logic we, input logic [1:0] idx, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic [1:0] exp_resp, input int lat,
                          input bit push, output int acc);
        exp_t e;
        @(posedge ACLK); #1;
        if (port == 0) begin req0_valid = 1; req0_we = we; req0_idx = idx; req0_wdata = wdata; end
        else           begin req1_valid = 1; req1_we = we; req1_idx = idx; req1_wdata = wdata; end
        acc = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge ACLK);
            if ((port == 0 && req0_ready) || (port == 1 && req1_ready)) begin
                acc = cyc;
                break;
            end
        end
        check(port == 0 ? "req0_accepted" : "req1_accepted", 32'(acc >= 0), 1);
        if (acc >= 0 && push) begin
            e.rdata = exp_rdata; e.resp = exp_resp; e.cyc = (lat > 0) ? acc + lat : -1;
            if (port == 0) q0.push_back(e); else q1.push_back(e);
        end
        @(posedge ACLK); #1;
        if (port == 0) req0_valid = 0; else req1_valid = 0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
            @(negedge ACLK);
            n++;
        end
        check(tag, 32'(q0.size() + q1.size()), 0);
        @(negedge ACLK);
    endtask

    initial begin
        logic [31:0] model [4];
        logic [31:0] wd [4];
        int acc0, acc1, awb, wvb, ovb, rr_seen;
        wd = '{32'h0101FFFF, 32'hABCD0001, 32'hDEAD0011, 32'hBEEF0011};
        for (int i = 0; i < 4; i++) begin model[i] = '0; smem[i] = '0; end

        #500;
        check("rst_awvalid", {31'b0, M_AXI_AWVALID}, 0);
        check("rst_wvalid", {31'b0, M_AXI_WVALID}, 0);
        check("rst_arvalid", {31'b0, M_AXI_ARVALID}, 0);
        check("rst_ready_bus", {30'b0, M_AXI_BREADY, M_AXI_RREADY}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_err_cnt", {24'b0, err_cnt}, 0);
        check("rst_req_ready", {30'b0, req0_ready, req1_ready}, 0);
        check("rst_resp_valid", {30'b0, resp0_valid, resp1_valid}, 0);
        check("rst_awaddr", M_AXI_AWADDR, 0);
        check("rst_resp0_rdata", resp0_rdata, 0);
        @(negedge ACLK);
        ARESETN = 1;

        for (int i = 0; i < 4; i++) begin
            model[i] = wd[i];
            do_req(0, 1'b1, 2'(i), wd[i], 32'h0, 2'b00, 4, 1, acc0);
            drain("wr_drain");
            check("wr_awaddr", cap_awaddr, BASE + 32'(4 * i));
            check("wr_wdata", cap_wdata, wd[i]);
            check("wr_wstrb", {28'b0, cap_wstrb}, 32'hF);
            check("wr_awprot", {29'b0, cap_awprot}, 0);
            do_req(0, 1'b0, 2'(i), 32'h0, model[i], 2'b00, 4, 1, acc0);
            drain("rd_drain");
            check("rd_araddr", cap_araddr, BASE + 32'(4 * i));
            check("rd_arprot", {29'b0, cap_arprot}, 0);
        end

        // one req1 transaction so req1 is the last grant going into the first tie
        do_req(1, 1'b0, 2'd1, 32'h0, model[1], 2'b00, 4, 1, acc1);
        drain("req1_rd_drain");

        model[2] = 32'h11112222;
        fork
            do_req(0, 1'b1, 2'd2, 32'h11112222, 32'h0, 2'b00, 4, 1, acc0);
            do_req(1, 1'b0, 2'd3, 32'h0, model[3], 2'b00, 4, 1, acc1);
        join
        drain("pair1_drain");
        check("pair1_req0_first", 32'(acc0 < acc1), 1);
        check("pair1_gap", 32'(acc1 - acc0), 4);

        do_req(0, 1'b0, 2'd2, 32'h0, model[2], 2'b00, 4, 1, acc0);
        drain("mid_drain");

        model[1] = 32'h5555AAAA;
        fork
            do_req(0, 1'b0, 2'd0, 32'h0, model[0], 2'b00, 4, 1, acc0);
            do_req(1, 1'b1, 2'd1, 32'h5555AAAA, 32'h0, 2'b00, 4, 1, acc1);
        join
        drain("pair2_drain");
        check("pair2_req1_first", 32'(acc1 < acc0), 1);
        do_req(0, 1'b0, 2'd1, 32'h0, model[1], 2'b00, 4, 1, acc0);
        drain("pair2_readback");

        // AW held off for 3 cycles while W is accepted straight away
        aw_delay = 3;
        awb = awv_cnt; wvb = wv_cnt; ovb = ovl_cnt;
        model[3] = 32'h12345678;
        do_req(0, 1'b1, 2'd3, 32'h12345678, 32'h0, 2'b00, 7, 1, acc0);
        drain("skew_drain");
        aw_delay = 0;
        check("skew_awvalid_cycles", 32'(awv_cnt - awb), 4);
        check("skew_wvalid_cycles", 32'(wv_cnt - wvb), 1);
        check("skew_bready_overlap", 32'(ovl_cnt - ovb), 0);
        do_req(1, 1'b0, 2'd3, 32'h0, model[3], 2'b00, 4, 1, acc1);
        drain("skew_readback");

        bresp_err = 2'b10;
        do_req(1, 1'b1, 2'd0, 32'h0BAD0BAD, 32'h0, 2'b10, 4, 1, acc1);
        drain("err_drain");
        check("err_cnt_one", {24'b0, err_cnt}, 1);
        for (int k = 0; k < 253; k++)
            do_req(0, 1'b1, 2'(k), 32'(k), 32'h0, 2'b10, 4, 1, acc0);
        drain("err_loop_drain");
        check("err_cnt_254", {24'b0, err_cnt}, 32'hFE);
        do_req(0, 1'b1, 2'd1, 32'h0, 32'h0, 2'b10, 4, 1, acc0);
        drain("err_255_drain");
        check("err_cnt_255", {24'b0, err_cnt}, 32'hFF);
        do_req(1, 1'b1, 2'd2, 32'h0, 32'h0, 2'b10, 4, 1, acc1);
        drain("err_256_drain");
        check("err_cnt_sat", {24'b0, err_cnt}, 32'hFF);
        bresp_err = 2'b00;
        do_req(0, 1'b0, 2'd0, 32'h0, model[0], 2'b00, 4, 1, acc0);
        drain("err_model_intact");

        // reset while the read data phase is stalled
        r_withhold = 1;
        do_req(0, 1'b0, 2'd2, 32'h0, 32'h0, 2'b00, 0, 0, acc0);
        rr_seen = 0;
        for (int n = 0; n < 20 && !rr_seen; n++) begin
            if (M_AXI_RREADY) rr_seen = 1;
            else @(negedge ACLK);
        end
        check("abort_reached_rd_data", 32'(rr_seen), 1);
        ARESETN = 0;
        #1;
        check("abort_arvalid", {31'b0, M_AXI_ARVALID}, 0);
        check("abort_rready", {31'b0, M_AXI_RREADY}, 0);
        check("abort_busy", {31'b0, busy}, 0);
        check("abort_err_cnt", {24'b0, err_cnt}, 0);
        @(negedge ACLK);
        @(negedge ACLK);
        r_withhold = 0;
        ARESETN = 1;
        repeat (8) @(negedge ACLK);
        do_req(0, 1'b0, 2'd2, 32'h0, model[2], 2'b00, 4, 1, acc0);
        drain("post_abort_drain");
        check("post_abort_busy", {31'b0, busy}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed time %0t required below 500000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
